// File: rtl/trace_overlay.sv
// Waveform trace overlay: captures 512 samples into a ping-pong buffer and draws them
// as a connected trace over the incoming grid colour, with bank swaps only at frame start.
module trace_overlay #(
    parameter int unsigned X_MIN       = 30,
    parameter int unsigned Y_MAX       = 300,
    parameter logic [7:0]  TRACE_COLOR = 8'b1110_0000,
    parameter bit          TRIG_EN     = 1'b1,
    parameter logic [7:0]  TRIG_LEVEL  = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [7:0] color_in,
    input  logic       frame_start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] color,
    output logic       frame_swap
);

    typedef enum logic [1:0] {
        WAIT_TRIG = 2'd0,
        CAPTURE   = 2'd1,
        FULL      = 2'd2
    } state_t;

    localparam state_t     ARM_STATE = TRIG_EN ? WAIT_TRIG : CAPTURE;
    localparam logic [9:0] X_LO      = 10'(X_MIN);
    localparam logic [9:0] X_HI      = 10'(X_MIN + 511);
    localparam logic [9:0] Y_TOP     = 10'(Y_MAX);

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? b : a;
    endfunction

    state_t     state_q;
    logic [8:0] wr_ptr_q;
    logic       wr_bank_q;
    logic       disp_bank_q;
    logic       disp_valid_q;
    logic [7:0] prev_samp_q;
    logic       frame_swap_q;

    // Both banks live in one array; the top address bit selects the bank.
    logic [7:0] mem [0:1023];

    logic accept;
    logic is_trig;
    logic wr_en;

    assign s_ready    = !rst && (state_q != FULL);
    assign accept     = s_valid && s_ready;
    assign is_trig    = (s_data >= TRIG_LEVEL) && (prev_samp_q < TRIG_LEVEL);
    assign wr_en      = accept && ((state_q == CAPTURE) || ((state_q == WAIT_TRIG) && is_trig));
    assign frame_swap = frame_swap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARM_STATE;
            wr_ptr_q     <= 9'd0;
            wr_bank_q    <= 1'b0;
            disp_bank_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            prev_samp_q  <= 8'hFF;
            frame_swap_q <= 1'b0;
        end else begin
            frame_swap_q <= 1'b0;
            if (accept) begin
                prev_samp_q <= s_data;
            end
            case (state_q)
                WAIT_TRIG: begin
                    if (accept && is_trig) begin
                        wr_ptr_q <= 9'd1;
                        state_q  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (accept) begin
                        wr_ptr_q <= wr_ptr_q + 9'd1;
                        if (wr_ptr_q == 9'd511) begin
                            state_q <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (frame_start) begin
                        disp_bank_q  <= wr_bank_q;
                        wr_bank_q    <= ~wr_bank_q;
                        wr_ptr_q     <= 9'd0;
                        disp_valid_q <= 1'b1;
                        frame_swap_q <= 1'b1;
                        state_q      <= ARM_STATE;
                    end
                end
                default: state_q <= ARM_STATE;
            endcase
        end
    end

    // Stage 0: column decode and synchronous read from the display bank
    logic       in_x_p0;
    logic [8:0] rd_addr_p0;

    assign in_x_p0    = (x >= X_LO) && (x <= X_HI);
    assign rd_addr_p0 = 9'(x - X_LO);

    logic [7:0] cur_p1;
    logic [7:0] prev_col_p1;
    logic [7:0] color_in_p1;
    logic [9:0] y_p1;
    logic       in_x_p1;
    logic       first_col_p1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_q, wr_ptr_q}] <= s_data;
        end
        cur_p1       <= mem[{disp_bank_q, rd_addr_p0}];
        prev_col_p1  <= cur_p1;
        color_in_p1  <= color_in;
        y_p1         <= y;
        in_x_p1      <= in_x_p0;
        first_col_p1 <= (x == X_LO);
    end

    // Stage 1: vertical span between neighbouring samples keeps the trace connected
    logic signed [9:0] yv_p1;
    logic [7:0]        prev_p1;
    logic [7:0]        lo_p1;
    logic [7:0]        hi_p1;
    logic              in_y_p1;
    logic              lit_p1;

    assign yv_p1   = signed'(Y_TOP - y_p1);
    assign prev_p1 = first_col_p1 ? cur_p1 : prev_col_p1;
    assign lo_p1   = min8(prev_p1, cur_p1);
    assign hi_p1   = max8(prev_p1, cur_p1);
    assign in_y_p1 = (yv_p1 >= 10'sd0) && (yv_p1 <= 10'sd255);
    assign lit_p1  = disp_valid_q && in_x_p1 && in_y_p1 &&
                     (yv_p1[7:0] >= lo_p1) && (yv_p1[7:0] <= hi_p1);

    // Stage 2: output colour register
    logic [7:0] color_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            color_q <= 8'd0;
        end else begin
            color_q <= lit_p1 ? TRACE_COLOR : color_in_p1;
        end
    end

    assign color = color_q;

endmodule

// File: tb/tb_trace_overlay.sv
// Bench for trace_overlay: one free-running (TRIG_EN=0) and one triggered (TRIG_EN=1) instance
// share the pixel stream; pixel colours are scored against a behavioural model via queues.
module tb_trace_overlay;

    localparam int         XM = 30;
    localparam int         YM = 300;
    localparam logic [7:0] TC = 8'hE0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [9:0] x, y;
    logic [7:0] color_in;
    logic       a_fs, a_sv, a_rdy, a_swap;
    logic [7:0] a_sd, a_col;
    logic       b_fs, b_sv, b_rdy, b_swap;
    logic [7:0] b_sd, b_col;

    trace_overlay #(.TRIG_EN(1'b0)) dut_a (
        .clk(clk), .rst(rst), .x(x), .y(y), .color_in(color_in),
        .frame_start(a_fs), .s_data(a_sd), .s_valid(a_sv), .s_ready(a_rdy),
        .color(a_col), .frame_swap(a_swap)
    );

    trace_overlay #(.TRIG_EN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .x(x), .y(y), .color_in(color_in),
        .frame_start(b_fs), .s_data(b_sd), .s_valid(b_sv), .s_ready(b_rdy),
        .color(b_col), .frame_swap(b_swap)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    typedef struct {
        int         due;
        int         xi;
        int         yi;
        logic [7:0] exp;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];

    logic [7:0] dm  [2][512];
    logic [7:0] cap [2][512];
    bit         dv  [2];
    int         last_x;

    function automatic logic [7:0] exp_col(input int d, input int xi, input int yi,
                                           input logic [7:0] c, input int pxi);
        int cur, prv, yv, lo, hi;
        bit inx, iny;
        inx = (xi >= XM) && (xi <= XM + 511);
        cur = int'(dm[d][(xi - XM) & 511]);
        prv = (xi == XM) ? cur : int'(dm[d][(pxi - XM) & 511]);
        yv  = YM - yi;
        iny = (yv >= 0) && (yv <= 255);
        lo  = (prv < cur) ? prv : cur;
        hi  = (prv < cur) ? cur : prv;
        return (dv[d] && inx && iny && yv >= lo && yv <= hi) ? TC : c;
    endfunction

    ent_t ea, eb;
    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].due <= cyc) begin
            ea = qa.pop_front();
            if (ea.due == cyc) check($sformatf("a_col(%0d,%0d)", ea.xi, ea.yi), 32'(a_col), 32'(ea.exp));
            else check("a_sb_late", 32'(ea.due), 32'(cyc));
        end
        while (qb.size() > 0 && qb[0].due <= cyc) begin
            eb = qb.pop_front();
            if (eb.due == cyc) check($sformatf("b_col(%0d,%0d)", eb.xi, eb.yi), 32'(b_col), 32'(eb.exp));
            else check("b_sb_late", 32'(eb.due), 32'(cyc));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input int xi, input int yi);
        logic [7:0] c;
        ent_t       e;
        c        = 8'(xi * 7 + yi * 3) | 8'h01;
        x        = 10'(xi);
        y        = 10'(yi);
        color_in = c;
        e.due = cyc + 2;
        e.xi  = xi;
        e.yi  = yi;
        e.exp = exp_col(0, xi, yi, c, last_x);
        qa.push_back(e);
        e.exp = exp_col(1, xi, yi, c, last_x);
        qb.push_back(e);
        last_x = xi;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] v);
        bit ok;
        ok = 1'b0;
        if (d == 0) begin a_sv = 1'b1; a_sd = v; end
        else        begin b_sv = 1'b1; b_sd = v; end
        for (int i = 0; i < 4 && !ok; i++) begin
            ok = (d == 0) ? a_rdy : b_rdy;
            @(posedge clk);
            #1;
        end
        if (d == 0) a_sv = 1'b0;
        else        b_sv = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_swap(input int d, input bit want);
        if (d == 0) a_fs = 1'b1;
        else        b_fs = 1'b1;
        @(posedge clk);
        #1;
        a_fs = 1'b0;
        b_fs = 1'b0;
        check($sformatf("swap_pulse%0d", d), 32'((d == 0) ? a_swap : b_swap), 32'(want));
        if (want) begin
            check($sformatf("rdy_after_swap%0d", d), 32'((d == 0) ? a_rdy : b_rdy), 32'd1);
            dm[d] = cap[d];
            dv[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        check($sformatf("swap_1cyc%0d", d), 32'((d == 0) ? a_swap : b_swap), 32'd0);
    endtask

    task automatic capture_a(input int kind);
        logic [7:0] v;
        for (int i = 0; i < 512; i++) begin
            case (kind)
                0:       v = 8'(i);
                1:       v = 8'd100;
                2:       v = (i < 20) ? 8'd10 : 8'd50;
                default: v = 8'(255 - i);
            endcase
            cap[0][i] = v;
            send(0, v);
            if (i == 510) check("a_rdy_511", 32'(a_rdy), 32'd1);
        end
        check("a_full", 32'(a_rdy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0; color_in = '0;
        a_fs = 1'b0; a_sv = 1'b0; a_sd = '0;
        b_fs = 1'b0; b_sv = 1'b0; b_sd = '0;
        last_x = 0;
        dv[0] = 1'b0; dv[1] = 1'b0;
        for (int i = 0; i < 512; i++) begin
            dm[0][i] = '0; dm[1][i] = '0; cap[0][i] = '0; cap[1][i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy_a",  32'(a_rdy),  32'd0);
        check("rst_col_a",  32'(a_col),  32'd0);
        check("rst_swap_a", 32'(a_swap), 32'd0);
        check("rst_rdy_b",  32'(b_rdy),  32'd0);
        check("rst_col_b",  32'(b_col),  32'd0);
        rst = 1'b0;
        #1;
        check("post_rdy_a", 32'(a_rdy), 32'd1);
        check("post_rdy_b", 32'(b_rdy), 32'd1);

        // No trace before the first swap
        pix(XM + 5, 200); pix(130, 200); pix(800, 500);
        idle(3);

        // Ramp capture and render
        capture_a(0);
        do_swap(0, 1'b1);
        for (int xi = 127; xi <= 132; xi++) pix(xi, 200);
        pix(XM, YM); pix(284, 45); pix(285, 45); pix(286, 45); pix(800, 500);
        idle(3);

        // Constant 100
        capture_a(1);
        do_swap(0, 1'b1);
        pix(XM + 4, 200); pix(XM + 5, 200); pix(XM + 5, 201); pix(XM + 5, 199);
        pix(XM + 511, 200); pix(XM + 512, 200);
        idle(3);

        // Step 10 -> 50 between samples 19 and 20
        capture_a(2);
        do_swap(0, 1'b1);
        foreach (cap[0][i]) begin end
        for (int k = 0; k < 5; k++) begin
            int yr;
            case (k)
                0: yr = 249; 1: yr = 250; 2: yr = 270; 3: yr = 290; default: yr = 291;
            endcase
            for (int xi = XM + 18; xi <= XM + 21; xi++) pix(xi, yr);
        end
        idle(3);

        // frame_start coincident with the 512th accept: no swap until the next frame_start
        for (int i = 0; i < 511; i++) begin
            cap[0][i] = 8'(i * 5);
            send(0, 8'(i * 5));
        end
        cap[0][511] = 8'(511 * 5);
        check("coinc_rdy", 32'(a_rdy), 32'd1);
        a_sv = 1'b1; a_sd = 8'(511 * 5); a_fs = 1'b1;
        @(posedge clk);
        #1;
        a_sv = 1'b0; a_fs = 1'b0;
        check("coinc_noswap", 32'(a_swap), 32'd0);
        check("coinc_full",   32'(a_rdy),  32'd0);
        idle(2);
        check("coinc_hold", 32'(a_swap), 32'd0);
        do_swap(0, 1'b1);
        pix(XM, YM); pix(XM + 1, 295); pix(XM + 2, 289); pix(XM + 2, 290);
        idle(3);

        // Reset mid-capture blanks the display and restarts the write pointer
        for (int i = 0; i < 100; i++) send(0, 8'd77);
        rst = 1'b1; dv[0] = 1'b0; dv[1] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_col",  32'(a_col),  32'd0);
        check("mid_rst_swap", 32'(a_swap), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(a_rdy), 32'd1);
        pix(130, 200); pix(XM + 5, 200); pix(XM + 5, 201);
        idle(3);
        capture_a(3);
        do_swap(0, 1'b1);
        pix(XM, 45); pix(130, 145); pix(131, 145); pix(131, 146);
        idle(3);

        // Triggered instance: 200 and 90 discarded, 130 is sample 0
        send(1, 8'd200);
        send(1, 8'd90);
        check("b_wait_rdy", 32'(b_rdy), 32'd1);
        send(1, 8'd130);
        cap[1][0] = 8'd130;
        for (int j = 1; j < 512; j++) begin
            cap[1][j] = 8'(j * 3);
            send(1, 8'(j * 3));
            if (j == 510) check("b_rdy_511", 32'(b_rdy), 32'd1);
        end
        check("b_full", 32'(b_rdy), 32'd0);
        do_swap(1, 1'b1);
        pix(XM, 170); pix(XM, 171); pix(XM + 1, 297); pix(XM + 1, 200); pix(XM + 2, 294);
        idle(3);

        // A stream held above the level never triggers
        for (int i = 0; i < 600; i++) send(1, 8'd200);
        check("b_hold_rdy", 32'(b_rdy), 32'd1);
        do_swap(1, 1'b0);
        pix(XM, 170); pix(XM + 1, 297);
        idle(3);

        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) idle(1);
        check("drain_a", 32'(qa.size()), 32'd0);
        check("drain_b", 32'(qb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
